ysyx_25080199_wbu: RTL and testbench

Writeback unit for the NPC core. It accepts results from the EXU and the LSU over valid/ready handshakes and arbitrates between them, one result per cycle. It drives the register file write port (`reg_we`/`reg_addr`/`reg_data`) from registered outputs. It also keeps a per-register pending-write scoreboard and tells the issue stage when to stall on RAW/WAW hazards.

---
 rtl/ysyx_25080199_wbu.sv | 102 ++++++++++
 tb/tb_ysyx_25080199_wbu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25080199_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the register file write port
// and keeps a per-register pending-write scoreboard for issue-stage hazard stalls.
module ysyx_25080199_wbu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic            iss_wen,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            reg_we,
    output logic [4:0]      reg_addr,
    output logic [XLEN-1:0] reg_data,
    output logic [31:0]     busy
);

    // 0 = EXU won the last conflict, 1 = LSU won it
    logic            last_grant_lsu;
    logic            conflict;
    logic            accept;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_data;
    logic            issue_fire;
    logic            set_en;
    logic [31:0]     busy_next;

    function automatic logic pending(input logic [31:0] sb, input logic [4:0] r);
        return (r != 5'd0) && sb[r];
    endfunction

    always_comb begin
        iss_stall = 1'b0;
        if (!rst && iss_valid) begin
            iss_stall = pending(busy, iss_rs1) || pending(busy, iss_rs2) ||
                        (iss_wen && pending(busy, iss_rd));
        end
    end

    assign issue_fire = iss_valid && !iss_stall && !rst;
    assign set_en     = issue_fire && iss_wen && (iss_rd != 5'd0);

    // Ready depends only on the valids, the conflict history and reset
    always_comb begin
        conflict  = !rst && exu_valid && lsu_valid;
        exu_ready = !rst && exu_valid && (!lsu_valid || last_grant_lsu);
        lsu_ready = !rst && lsu_valid && (!exu_valid || !last_grant_lsu);
    end

    always_comb begin
        accept   = exu_ready || lsu_ready;
        res_rd   = lsu_ready ? lsu_rd : exu_rd;
        res_data = lsu_ready ? lsu_data : exu_data;
    end

    // A fresh issue to r beats the retiring write to r on the same edge
    always_comb begin
        busy_next = '0;
        for (int r = 1; r < 32; r++) begin
            busy_next[r] = (busy[r] && !(reg_we && (reg_addr == 5'(r)))) ||
                           (set_en && (iss_rd == 5'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_lsu <= 1'b0;
            busy           <= '0;
        end else begin
            if (conflict) begin
                last_grant_lsu <= lsu_ready;
            end
            busy <= busy_next;
        end
    end

    // Writeback register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we   <= 1'b0;
            reg_addr <= 5'd0;
            reg_data <= '0;
        end else begin
            reg_we <= accept && (res_rd != 5'd0);
            if (accept && (res_rd != 5'd0)) begin
                reg_addr <= res_rd;
                reg_data <= res_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25080199_wbu.sv
// Bench for ysyx_25080199_wbu: directed stimulus, a behavioural model checked
// every cycle, and hand-computed literal expectations at key points.
module tb_ysyx_25080199_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_wen;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        iss_stall;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    ysyx_25080199_wbu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: set of pending registers, who gets the next conflict,
    // and the last write presented to the register file.
    bit          pend_m [32];
    bit          lsu_next_m = 1'b1;
    logic        we_m = 1'b0;
    logic [4:0]  addr_m = '0;
    logic [31:0] data_m = '0;

    function automatic logic is_pending(input logic [4:0] r);
        return (r != 0) && pend_m[r];
    endfunction

    function automatic logic exp_stall();
        if (rst || !iss_valid) return 1'b0;
        return is_pending(iss_rs1) || is_pending(iss_rs2) || (iss_wen && is_pending(iss_rd));
    endfunction

    function automatic logic exp_exu_ready();
        if (rst || !exu_valid) return 1'b0;
        return !lsu_valid || !lsu_next_m;
    endfunction

    function automatic logic exp_lsu_ready();
        if (rst || !lsu_valid) return 1'b0;
        return !exu_valid || lsu_next_m;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) v[r] = pend_m[r];
        return v;
    endfunction

    always @(posedge clk) begin
        logic       take_exu, take_lsu, do_issue;
        logic [4:0] wr_rd;
        logic [31:0] wr_data;
        if (rst) begin
            for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
            lsu_next_m = 1'b1;
            we_m = 1'b0; addr_m = '0; data_m = '0;
        end else begin
            take_exu = exp_exu_ready();
            take_lsu = exp_lsu_ready();
            do_issue = iss_valid && !exp_stall() && iss_wen && iss_rd != 0;
            if (exu_valid && lsu_valid) lsu_next_m = !lsu_next_m;
            if (we_m) pend_m[addr_m] = 1'b0;
            if (do_issue) pend_m[iss_rd] = 1'b1;
            wr_rd   = take_lsu ? lsu_rd : exu_rd;
            wr_data = take_lsu ? lsu_data : exu_data;
            if ((take_exu || take_lsu) && wr_rd != 0) begin
                we_m = 1'b1; addr_m = wr_rd; data_m = wr_data;
            end else begin
                we_m = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_iss_stall", 32'(iss_stall), 32'(exp_stall()));
        chk("model_exu_ready", 32'(exu_ready), 32'(exp_exu_ready()));
        chk("model_lsu_ready", 32'(lsu_ready), 32'(exp_lsu_ready()));
        chk("model_reg_we", 32'(reg_we), 32'(we_m));
        chk("model_reg_addr", 32'(reg_addr), 32'(addr_m));
        chk("model_reg_data", reg_data, data_m);
        chk("model_busy", busy, pend_vec());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic w, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = v; iss_wen = w; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
    endtask

    initial begin
        rst = 1'b1;
        issue(0, 0, 0, 0, 0);
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'hDEADBEEF;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;

        // reset with a presented EXU result
        @(negedge clk);
        chk("rst_exu_ready", 32'(exu_ready), 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_busy", busy, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_reg_data", reg_data, 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        tick();
        rst = 1'b0; exu_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_no_write", 32'(reg_we), 32'd0);

        // single EXU result
        issue(1, 1, 5'd5, 0, 0);
        tick();
        issue(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("busy5_set", 32'(busy[5]), 32'd1);
        tick();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h12345678;
        @(negedge clk);
        chk("exu5_ready", 32'(exu_ready), 32'd1);
        tick();
        exu_valid = 1'b0;
        @(negedge clk);
        chk("exu5_we", 32'(reg_we), 32'd1);
        chk("exu5_addr", 32'(reg_addr), 32'd5);
        chk("exu5_data", reg_data, 32'h12345678);
        chk("busy5_still", 32'(busy[5]), 32'd1);
        tick();
        @(negedge clk);
        chk("busy5_clear", 32'(busy[5]), 32'd0);
        chk("exu5_we_drop", 32'(reg_we), 32'd0);

        // RAW stall on x3
        tick();
        issue(1, 1, 5'd3, 0, 0);
        tick();
        issue(1, 0, 0, 5'd3, 0);
        @(negedge clk);
        chk("raw3_stall", 32'(iss_stall), 32'd1);
        tick();
        issue(1, 1, 5'd4, 0, 0);
        @(negedge clk);
        chk("rs0_no_stall", 32'(iss_stall), 32'd0);
        tick();
        issue(1, 0, 0, 5'd3, 0);
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hA5A50003;
        @(negedge clk);
        chk("raw3_stall_n", 32'(iss_stall), 32'd1);
        tick();
        exu_valid = 1'b0;
        @(negedge clk);
        chk("raw3_stall_n1", 32'(iss_stall), 32'd1);
        chk("raw3_addr", 32'(reg_addr), 32'd3);
        tick();
        @(negedge clk);
        chk("raw3_release", 32'(iss_stall), 32'd0);
        tick();
        issue(0, 0, 0, 0, 0);

        // conflict fairness: LSU, EXU, LSU
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h11111111;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22222222;
        @(negedge clk);
        chk("cf1_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("cf1_exu_ready", 32'(exu_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("cf2_exu_ready", 32'(exu_ready), 32'd1);
        chk("cf2_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("cf1_addr", 32'(reg_addr), 32'd2);
        chk("cf1_data", reg_data, 32'h22222222);
        tick();
        @(negedge clk);
        chk("cf3_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("cf2_addr", 32'(reg_addr), 32'd1);
        chk("cf2_data", reg_data, 32'h11111111);
        tick();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        chk("cf3_addr", 32'(reg_addr), 32'd2);
        chk("cf3_we", 32'(reg_we), 32'd1);
        tick();

        // set wins over clear on the same register and edge
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h00000099;
        tick();
        exu_valid = 1'b0;
        issue(1, 1, 5'd9, 0, 0);
        @(negedge clk);
        chk("sw_addr", 32'(reg_addr), 32'd9);
        chk("sw_no_stall", 32'(iss_stall), 32'd0);
        tick();
        issue(0, 0, 0, 0, 0);
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h00000999;
        @(negedge clk);
        chk("sw_busy9", 32'(busy[9]), 32'd1);
        tick();
        exu_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("sw_busy9_clear", 32'(busy[9]), 32'd0);

        // rd=0 result is dropped but still handshakes
        tick();
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rd0_ready", 32'(exu_ready), 32'd1);
        tick();
        exu_valid = 1'b0;
        @(negedge clk);
        chk("rd0_no_we", 32'(reg_we), 32'd0);
        chk("rd0_busy", busy, 32'h00000010);

        // reset in the middle of a pending write to x7
        tick();
        issue(1, 1, 5'd7, 0, 0);
        tick();
        issue(0, 0, 0, 0, 0);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h00000077;
        @(negedge clk);
        chk("mr_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("mr_busy", busy, 32'h00000090);
        tick();
        lsu_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mr_we_before", 32'(reg_we), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_we_after", 32'(reg_we), 32'd0);
        chk("mr_busy_after", busy, 32'd0);
        tick();
        tick();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
